// File: rtl/rr_mux_pkg.sv
// Shared constants, FSM state type and round-robin scan helper for rr_mux_arbiter.
package rr_mux_pkg;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned SEL_W = 2;

    typedef enum logic [0:0] {
        StIdle,
        StGrant
    } state_e;

    // First set request scanning ptr+1, ptr+2, ..., ptr (mod N_REQ); returns ptr if none set.
    function automatic logic [SEL_W-1:0] rr_next(input logic [SEL_W-1:0] ptr,
                                                 input logic [N_REQ-1:0] req);
        logic [SEL_W-1:0] idx;
        rr_next = ptr;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = ptr + SEL_W'(k);
            if (req[idx]) rr_next = idx;
        end
    endfunction

endpackage

// File: rtl/mux4_w.sv
// Combinational WIDTH-wide 4:1 word multiplexer.
module mux4_w
    import rr_mux_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [N_REQ*WIDTH-1:0] din_i,
    input  logic [SEL_W-1:0]       sel_i,
    output logic [WIDTH-1:0]       dout_o
);

    always_comb begin
        dout_o = din_i[0 +: WIDTH];
        unique case (sel_i)
            2'd0: dout_o = din_i[0*WIDTH +: WIDTH];
            2'd1: dout_o = din_i[1*WIDTH +: WIDTH];
            2'd2: dout_o = din_i[2*WIDTH +: WIDTH];
            2'd3: dout_o = din_i[3*WIDTH +: WIDTH];
            default: dout_o = din_i[0 +: WIDTH];
        endcase
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter for a shared 4:1 data mux with bounded bursts and a registered
// valid/ready output stage.
module rr_mux_arbiter
    import rr_mux_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] din,
    output logic [N_REQ-1:0]       ack,
    output logic [N_REQ-1:0]       gnt,
    output logic [SEL_W-1:0]       sel,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy
);

    localparam logic [3:0] BeatLast = 4'(MAX_BURST - 1);

    state_e             state_q;
    logic [SEL_W-1:0]   ptr_q;
    logic [N_REQ-1:0]   gnt_q;
    logic [SEL_W-1:0]   sel_q;
    logic [3:0]         beat_q;
    logic [WIDTH-1:0]   out_data_q;
    logic               out_valid_q;
    logic               busy_q;

    logic [WIDTH-1:0]   mux_word;
    logic [SEL_W-1:0]   pick_d;
    logic               owner_req;
    logic               load;
    logic               grant_end;

    mux4_w #(
        .WIDTH (WIDTH)
    ) u_mux (
        .din_i  (din),
        .sel_i  (sel_q),
        .dout_o (mux_word)
    );

    always_comb begin
        pick_d    = rr_next(ptr_q, req);
        owner_req = req[sel_q];
        load      = (state_q == StGrant) && owner_req && (!out_valid_q || out_ready);
        grant_end = !owner_req || (load && (beat_q == BeatLast));
        ack       = '0;
        // Reset wins over any in-flight transfer, so never pop while rst_n is low.
        if (load && rst_n) ack[sel_q] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            ptr_q       <= SEL_W'(N_REQ - 1);
            gnt_q       <= '0;
            sel_q       <= '0;
            beat_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            // Output stage drains regardless of FSM state.
            if (load) begin
                out_data_q  <= mux_word;
                out_valid_q <= 1'b1;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end

            case (state_q)
                StIdle: begin
                    if (|req) begin
                        state_q <= StGrant;
                        gnt_q   <= N_REQ'(1) << pick_d;
                        sel_q   <= pick_d;
                        beat_q  <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                StGrant: begin
                    if (grant_end) begin
                        state_q <= StIdle;
                        gnt_q   <= '0;
                        ptr_q   <= sel_q;
                        beat_q  <= '0;
                        busy_q  <= 1'b0;
                    end else if (load) begin
                        beat_q  <= beat_q + 4'd1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed and random stimulus for rr_mux_arbiter against a cycle-level behavioural model.
module tb_rr_mux_arbiter;

    localparam int WIDTH     = 8;
    localparam int MAX_BURST = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [3:0]       req;
    logic [4*WIDTH-1:0] din;
    logic [3:0]       ack;
    logic [3:0]       gnt;
    logic [1:0]       sel;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             busy;

    always #5 clk = ~clk;

    rr_mux_arbiter #(
        .WIDTH     (WIDTH),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .din       (din),
        .ack       (ack),
        .gnt       (gnt),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Model: owner -1 means no grant; sent counts words popped in the current grant.
    int         m_owner = -1;
    int         m_ptr   = 3;
    int         m_sel   = 0;
    int         m_sent  = 0;
    logic       m_vld   = 1'b0;
    logic [7:0] m_data  = 8'h00;
    bit         m_known = 1'b0;

    int         seq[4];
    int         order_q[$];
    logic [3:0] prev_gnt = 4'h0;

    function automatic logic [7:0] word_of(input int i);
        return 8'((i << 6) | (seq[i] & 63));
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cycle(input logic r, input logic [3:0] q, input logic rd);
        logic [3:0] eack;
        bit         load;
        int         c;
        rst_n     = r;
        req       = q;
        out_ready = rd;
        for (int i = 0; i < 4; i++) din[i*WIDTH +: WIDTH] = word_of(i);
        #1;
        eack = 4'h0;
        if (r && m_owner >= 0 && q[m_owner] && (!m_vld || rd)) eack[m_owner] = 1'b1;
        chk("ack", 32'(ack), 32'(eack));
        if (m_known) begin
            chk("gnt", 32'(gnt), (m_owner >= 0) ? 32'(1 << m_owner) : 32'd0);
            chk("sel", 32'(sel), 32'(m_sel));
            chk("out_valid", 32'(out_valid), 32'(m_vld));
            chk("out_data", 32'(out_data), 32'(m_data));
            chk("busy", 32'(busy), (m_owner >= 0) ? 32'd1 : 32'd0);
        end
        if (gnt != 4'h0 && prev_gnt == 4'h0) begin
            for (int i = 0; i < 4; i++) if (gnt[i]) order_q.push_back(i);
        end
        prev_gnt = gnt;

        @(posedge clk);
        load = (eack != 4'h0);
        if (!r) begin
            m_owner = -1; m_ptr = 3; m_sel = 0; m_sent = 0;
            m_vld = 1'b0; m_data = 8'h00; m_known = 1'b1;
        end else begin
            if (load) begin
                m_data = word_of(m_owner);
                m_vld  = 1'b1;
                seq[m_owner]++;
            end else if (rd) begin
                m_vld = 1'b0;
            end
            if (m_owner < 0) begin
                for (int k = 1; k <= 4; k++) begin
                    c = (m_ptr + k) % 4;
                    if (m_owner < 0 && q[c]) begin
                        m_owner = c; m_sel = c; m_sent = 0;
                    end
                end
            end else if (!q[m_owner] || (load && m_sent + 1 == MAX_BURST)) begin
                m_ptr   = m_owner;
                m_owner = -1;
                m_sent  = 0;
            end else if (load) begin
                m_sent++;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        logic [3:0] rq;
        logic       rd;
        logic       rr;
        rst_n = 1'b0; req = 4'h0; out_ready = 1'b1; din = '0;
        for (int i = 0; i < 4; i++) seq[i] = 0;
        @(negedge clk);

        // Reset held with all requests pending.
        repeat (3) cycle(1'b0, 4'hF, 1'b1);
        chk("rst_gnt", 32'(gnt), 32'd0);

        // Full round robin: five grants in order 0,1,2,3,0.
        order_q.delete();
        repeat (25) cycle(1'b1, 4'hF, 1'b1);
        chk("rr_count_ok", (order_q.size() >= 5) ? 32'd1 : 32'd0, 32'd1);
        for (int i = 0; i < 5; i++)
            chk("rr_order", (i < order_q.size()) ? 32'(order_q[i]) : 32'hFFFF_FFFF, 32'(i % 4));

        // Early drop by requester 1, then requester 0 wins next.
        repeat (3) cycle(1'b1, 4'h0, 1'b1);
        repeat (3) cycle(1'b1, 4'b0010, 1'b1);
        cycle(1'b1, 4'h0, 1'b1);
        cycle(1'b1, 4'b0011, 1'b1);
        chk("early_gnt", 32'(gnt), 32'd1);

        // Backpressure mid-burst.
        repeat (2) cycle(1'b1, 4'hF, 1'b1);
        repeat (5) cycle(1'b1, 4'hF, 1'b0);
        repeat (6) cycle(1'b1, 4'hF, 1'b1);

        // Wrap/priority from reset pointer: 0, 3, 0.
        cycle(1'b0, 4'h0, 1'b1);
        order_q.delete();
        repeat (16) cycle(1'b1, 4'b1001, 1'b1);
        for (int i = 0; i < 3; i++)
            chk("wrap_order", (i < order_q.size()) ? 32'(order_q[i]) : 32'hFFFF_FFFF,
                (i == 1) ? 32'd3 : 32'd0);

        // Reset after two beats of a burst.
        repeat (2) cycle(1'b1, 4'h0, 1'b1);
        repeat (3) cycle(1'b1, 4'hF, 1'b1);
        cycle(1'b0, 4'hF, 1'b1);
        chk("mid_rst_gnt", 32'(gnt), 32'd0);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_data", 32'(out_data), 32'd0);
        cycle(1'b1, 4'hF, 1'b1);
        chk("mid_rst_regrant", 32'(gnt), 32'd1);

        // Random traffic with backpressure, drops and occasional reset.
        rq = 4'h0;
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < 4; b++) if ($urandom_range(7) == 0) rq[b] = ~rq[b];
            rd = ($urandom_range(3) != 0);
            rr = ($urandom_range(199) != 0);
            cycle(rr, rq, rd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
